// File: rtl/snn_ni_pkg.sv
// Shared constants, FSM state type and packet field helpers for the SNN
// tile network interface.
package snn_ni_pkg;

  localparam logic [1:0] CFG_NADDR = 2'd0;
  localparam logic [1:0] CFG_PTR   = 2'd1;
  localparam logic [1:0] CFG_DOWN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    SEND
  } ni_state_t;

  // Widest address the packet helpers can slice.
  localparam int PKT_ADDR_MAX = 32;

  function automatic logic [PKT_ADDR_MAX-1:0] pkt_dst(
    input logic [2*PKT_ADDR_MAX-1:0] pkt,
    input int unsigned               addr_w
  );
    logic [2*PKT_ADDR_MAX-1:0] mask;
    mask = ((2*PKT_ADDR_MAX)'(1) << addr_w) - (2*PKT_ADDR_MAX)'(1);
    return PKT_ADDR_MAX'(pkt & mask);
  endfunction

  function automatic logic [PKT_ADDR_MAX-1:0] pkt_src(
    input logic [2*PKT_ADDR_MAX-1:0] pkt,
    input int unsigned               addr_w
  );
    logic [2*PKT_ADDR_MAX-1:0] mask;
    mask = ((2*PKT_ADDR_MAX)'(1) << addr_w) - (2*PKT_ADDR_MAX)'(1);
    return PKT_ADDR_MAX'((pkt >> addr_w) & mask);
  endfunction

endpackage

// File: rtl/snn_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above start,
// wrapping around N.
module snn_rr_arbiter #(
  parameter  int N     = 10,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]   rot;
  logic [IDX_W:0] sum;

  always_comb begin
    // rot[i] is the request of neuron (start + i) mod N
    rot = N'({req, req} >> start);
    any = 1'b0;
    idx = '0;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        sum = {1'b0, start} + (IDX_W+1)'(i);
        idx = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N)) : IDX_W'(sum);
      end
    end
    grant = any ? (N'(1) << idx) : {N{1'b0}};
  end

endmodule

// File: rtl/network_interface_csr.sv
// SNN tile spike fan-out: latches spikes, serves them round-robin and walks
// each neuron's CSR connection list, delivering locally or as NoC packets.
module network_interface_csr
  import snn_ni_pkg::*;
#(
  parameter  int N_NEURONS = 10,
  parameter  int ADDR_W    = 12,
  parameter  int MAX_CONN  = 32,
  parameter  int TILE_ID   = 0,
  localparam int LOCAL_W   = $clog2(N_NEURONS),
  localparam int PTR_W     = $clog2(MAX_CONN + 1)
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        clear,
  input  logic [N_NEURONS-1:0]        spike_in,
  input  logic                        cfg_we,
  input  logic [1:0]                  cfg_sel,
  input  logic [PTR_W-1:0]            cfg_addr,
  input  logic [ADDR_W-1:0]           cfg_data,
  output logic                        cfg_drop,
  output logic [N_NEURONS*ADDR_W-1:0] local_src,
  output logic [N_NEURONS-1:0]        local_valid,
  output logic                        pkt_valid,
  input  logic                        pkt_ready,
  output logic [2*ADDR_W-1:0]         pkt_data,
  output logic                        busy,
  output logic                        dest_err
);

  localparam int DOWN_W  = $clog2(MAX_CONN);
  localparam int CPTR_IW = $clog2(N_NEURONS + 1);
  localparam int TAG_W   = ADDR_W - LOCAL_W;

  ni_state_t state_reg, state_next;
  logic [N_NEURONS-1:0] pending_reg, grant, local_valid_reg;
  logic [LOCAL_W-1:0]   rr_ptr_reg, cur_reg, sel_idx, dest_idx;
  logic [PTR_W-1:0]     j_reg, end_reg;
  logic [ADDR_W-1:0]    naddr_reg [N_NEURONS];
  logic [PTR_W-1:0]     cptr_reg  [N_NEURONS+1];
  logic [ADDR_W-1:0]    down_reg  [MAX_CONN];
  logic [ADDR_W-1:0]    slot_reg  [N_NEURONS];
  logic [2*ADDR_W-1:0]  pkt_data_reg;
  logic [ADDR_W-1:0]    dest;
  logic pkt_valid_reg, cfg_drop_reg, dest_err_reg, sel_any, cfg_ok;
  logic do_select, do_local, do_err, do_remote, do_advance, do_sent;
  logic walk_done, dest_on_tile;

  snn_rr_arbiter #(.N(N_NEURONS)) u_arb (
    .req   (pending_reg),
    .start (rr_ptr_reg),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  assign dest         = down_reg[j_reg[DOWN_W-1:0]];
  assign dest_idx     = dest[LOCAL_W-1:0];
  assign dest_on_tile = (dest[ADDR_W-1:LOCAL_W] == TAG_W'(TILE_ID));
  // A pointer past the table end terminates the walk as well as j >= end.
  assign walk_done    = (j_reg >= end_reg) || (j_reg >= PTR_W'(MAX_CONN));

  always_comb begin
    state_next = state_reg;
    do_select  = 1'b0;
    do_local   = 1'b0;
    do_err     = 1'b0;
    do_remote  = 1'b0;
    do_advance = 1'b0;
    do_sent    = 1'b0;
    unique case (state_reg)
      IDLE: if (sel_any) begin
        do_select  = 1'b1;
        state_next = WALK;
      end
      WALK: begin
        if (walk_done) begin
          state_next = IDLE;
        end else if (!dest_on_tile) begin
          do_remote  = 1'b1;
          state_next = SEND;
        end else if (int'(dest_idx) < N_NEURONS) begin
          do_local   = 1'b1;
          do_advance = 1'b1;
        end else begin
          do_err     = 1'b1;
          do_advance = 1'b1;
        end
      end
      SEND: if (pkt_ready) begin
        do_sent    = 1'b1;
        do_advance = 1'b1;
        state_next = WALK;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_ok = 1'b0;
    if (state_reg == IDLE && pending_reg == '0) begin
      case (cfg_sel)
        CFG_NADDR: cfg_ok = (int'(cfg_addr) < N_NEURONS);
        CFG_PTR:   cfg_ok = (int'(cfg_addr) <= N_NEURONS);
        CFG_DOWN:  cfg_ok = (int'(cfg_addr) < MAX_CONN);
        default:   cfg_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg       <= IDLE;
      pending_reg     <= '0;
      rr_ptr_reg      <= '0;
      cur_reg         <= '0;
      j_reg           <= '0;
      end_reg         <= '0;
      local_valid_reg <= '0;
      pkt_valid_reg   <= 1'b0;
      pkt_data_reg    <= '0;
      cfg_drop_reg    <= 1'b0;
      dest_err_reg    <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        naddr_reg[i] <= ADDR_W'((TILE_ID << LOCAL_W) | i);
        slot_reg[i]  <= '0;
      end
      for (int i = 0; i <= N_NEURONS; i++) cptr_reg[i] <= '0;
      for (int i = 0; i < MAX_CONN; i++) down_reg[i] <= '0;
    end else begin
      cfg_drop_reg <= cfg_we && !cfg_ok;
      dest_err_reg <= 1'b0;
      if (cfg_we && cfg_ok) begin
        case (cfg_sel)
          CFG_NADDR: naddr_reg[cfg_addr[LOCAL_W-1:0]] <= cfg_data;
          CFG_PTR:   cptr_reg[cfg_addr[CPTR_IW-1:0]]  <= cfg_data[PTR_W-1:0];
          default:   down_reg[cfg_addr[DOWN_W-1:0]]   <= cfg_data;
        endcase
      end
      if (clear) begin
        state_reg       <= IDLE;
        pending_reg     <= '0;
        local_valid_reg <= '0;
        pkt_valid_reg   <= 1'b0;
        for (int i = 0; i < N_NEURONS; i++) slot_reg[i] <= '0;
      end else begin
        state_reg   <= state_next;
        // A spike on the neuron being selected re-arms it for another pass.
        pending_reg <= (pending_reg & ~(do_select ? grant : {N_NEURONS{1'b0}})) | spike_in;
        if (do_select) begin
          cur_reg    <= sel_idx;
          rr_ptr_reg <= (int'(sel_idx) == N_NEURONS - 1) ? {LOCAL_W{1'b0}} : sel_idx + 1'b1;
          j_reg      <= cptr_reg[CPTR_IW'(sel_idx)];
          end_reg    <= cptr_reg[CPTR_IW'(sel_idx) + CPTR_IW'(1)];
        end
        if (do_advance) j_reg <= j_reg + 1'b1;
        if (do_local) begin
          slot_reg[dest_idx]        <= naddr_reg[cur_reg];
          local_valid_reg[dest_idx] <= 1'b1;
        end
        if (do_err) dest_err_reg <= 1'b1;
        if (do_remote) begin
          pkt_valid_reg <= 1'b1;
          pkt_data_reg  <= {naddr_reg[cur_reg], dest};
        end
        if (do_sent) pkt_valid_reg <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_slot
      assign local_src[gi*ADDR_W +: ADDR_W] = slot_reg[gi];
    end
  endgenerate

  assign local_valid = local_valid_reg;
  assign pkt_valid   = pkt_valid_reg;
  assign pkt_data    = pkt_data_reg;
  assign cfg_drop    = cfg_drop_reg;
  assign dest_err    = dest_err_reg;
  assign busy        = (state_reg != IDLE) || (pending_reg != '0);

endmodule

// File: tb/tb_network_interface_csr.sv
// Directed bench for network_interface_csr: CSR programming, local fan-out,
// remote packet handshake, round-robin order, clear and async reset.
module tb_network_interface_csr;
  import snn_ni_pkg::*;

  localparam int N  = 10;
  localparam int AW = 12;
  localparam int MC = 32;
  localparam int PW = 6;

  logic          CLK, RESET_N, clear, cfg_we, cfg_drop;
  logic          pkt_valid, pkt_ready, busy, dest_err;
  logic [N-1:0]  spike_in, local_valid;
  logic [1:0]    cfg_sel;
  logic [PW-1:0] cfg_addr;
  logic [AW-1:0] cfg_data;
  logic [N*AW-1:0] local_src, exp_src;
  logic [2*AW-1:0] pkt_data;

  int checks = 0;
  int failures = 0;
  int ptr_v [6] = '{3, 3, 3, 4, 5, 6};
  logic [AW-1:0] down_v [6] = '{12'h003, 12'h005, 12'h007, 12'h001, 12'h00C, 12'h002};

  network_interface_csr #(
    .N_NEURONS (N),
    .ADDR_W    (AW),
    .MAX_CONN  (MC),
    .TILE_ID   (0)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .clear       (clear),
    .spike_in    (spike_in),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_drop    (cfg_drop),
    .local_src   (local_src),
    .local_valid (local_valid),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_data    (pkt_data),
    .busy        (busy),
    .dest_err    (dest_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] slot(input int k);
    return local_src[k*AW +: AW];
  endfunction

  task automatic cfg_write(input logic [1:0] sel, input logic [PW-1:0] addr, input logic [AW-1:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic spike(input logic [N-1:0] v);
    spike_in = v;
    tick();
    spike_in = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; clear = 1'b0; spike_in = '0; cfg_we = 1'b0;
    cfg_sel = '0; cfg_addr = '0; cfg_data = '0; pkt_ready = 1'b0;
    tick(); tick();
    check("rst_valid", local_valid, 0);
    check("rst_src", local_src, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_pkt_data", pkt_data, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {cfg_drop, dest_err}, 0);
    RESET_N = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) cfg_write(CFG_PTR, PW'(i + 1), AW'(ptr_v[i]));
    check("cfg_ptr_ok", cfg_drop, 0);
    for (int i = 0; i < 6; i++) cfg_write(CFG_DOWN, PW'(i), down_v[i]);
    check("cfg_down_ok", cfg_drop, 0);
    cfg_write(2'd3, 6'd0, 12'h123);
    check("drop_sel3", cfg_drop, 1);
    cfg_write(CFG_DOWN, 6'd32, 12'h123);
    check("drop_down_range", cfg_drop, 1);
    cfg_write(CFG_PTR, 6'd11, 12'h001);
    check("drop_ptr_range", cfg_drop, 1);
    cfg_write(CFG_NADDR, 6'd10, 12'h001);
    check("drop_naddr_range", cfg_drop, 1);
    tick();
    check("drop_pulse_end", cfg_drop, 0);

    // Neuron 0 fans out to local 3, 5, 7
    spike(10'h001);
    check("loc_busy_t", busy, 1);
    check("loc_lv_t", local_valid, 0);
    tick();
    check("loc_lv_t1", local_valid, 0);
    tick();
    check("loc_lv_t2", local_valid, 10'h008);
    check("loc_src3", slot(3), 12'h000);
    tick();
    check("loc_lv_t3", local_valid, 10'h028);
    tick();
    check("loc_lv_t4", local_valid, 10'h0A8);
    check("loc_busy_t4", busy, 1);
    tick();
    check("loc_busy_t5", busy, 0);

    do_clear();
    check("clr_lv", local_valid, 0);
    spike(10'h008);
    tick(); tick();
    check("n3_lv", local_valid, 10'h002);
    check("n3_src", slot(1), 12'h003);
    tick(); tick();

    // rr_ptr = 4: neuron 5 ahead of neuron 3
    do_clear();
    spike(10'h028);
    tick(); tick();
    check("rr_first5_lv", local_valid, 10'h004);
    check("rr_first5_src", slot(2), 12'h005);
    tick(); tick(); tick();
    check("rr_then3_lv", local_valid, 10'h006);
    check("rr_then3_src", slot(1), 12'h003);
    tick();
    check("rr_idle", busy, 0);

    // rr_ptr back at 4: neuron 4 (bad local index) ahead of 3
    do_clear();
    spike(10'h018);
    tick(); tick();
    check("err_pulse", dest_err, 1);
    check("err_no_write", local_valid, 0);
    tick();
    check("err_pulse_end", dest_err, 0);
    tick(); tick();
    check("err_then3", local_valid, 10'h002);
    tick();

    // Remote destination with back-pressure
    cfg_write(CFG_DOWN, 6'd0, 12'hFFB);
    check("cfg_remote_ok", cfg_drop, 0);
    do_clear();
    pkt_ready = 1'b0;
    spike(10'h001);
    tick(); tick();
    check("send_v1", pkt_valid, 1);
    check("send_d1", pkt_data, 24'h000FFB);
    tick();
    check("send_v2", pkt_valid, 1);
    check("send_d2", pkt_data, 24'h000FFB);
    cfg_we = 1'b1; cfg_sel = CFG_NADDR; cfg_addr = 6'd0; cfg_data = 12'h0A5;
    tick();
    cfg_we = 1'b0;
    check("drop_busy", cfg_drop, 1);
    check("send_v3", pkt_valid, 1);
    check("send_src", pkt_src(64'(pkt_data), AW), 12'h000);
    check("send_dst", pkt_dst(64'(pkt_data), AW), 12'hFFB);
    pkt_ready = 1'b1;
    tick();
    pkt_ready = 1'b0;
    check("send_done", pkt_valid, 0);
    check("send_no_local", local_valid, 0);
    tick();
    check("send_cont1", local_valid, 10'h020);
    tick();
    check("send_cont2", local_valid, 10'h0A0);
    tick();
    check("send_idle", busy, 0);

    // Clear mid-walk; dropped write must not have changed neuron_addr[0]
    cfg_write(CFG_DOWN, 6'd0, 12'h003);
    do_clear();
    spike(10'h001);
    tick(); tick();
    check("abort_first", local_valid, 10'h008);
    check("drop_no_effect", slot(3), 12'h000);
    do_clear();
    check("abort_lv", local_valid, 0);
    check("abort_idle", busy, 0);
    tick(); tick();
    check("abort_no_more", local_valid, 0);

    cfg_write(CFG_NADDR, 6'd0, 12'h0A5);
    check("cfg_idle_ok", cfg_drop, 0);
    spike(10'h001);
    tick(); tick(); tick(); tick();
    exp_src = '0;
    exp_src[3*AW +: AW] = 12'h0A5;
    exp_src[5*AW +: AW] = 12'h0A5;
    exp_src[7*AW +: AW] = 12'h0A5;
    check("naddr_src_all", local_src, exp_src);
    check("naddr_lv", local_valid, 10'h0A8);
    tick();

    // Async reset while in SEND
    cfg_write(CFG_DOWN, 6'd0, 12'hFFB);
    spike(10'h001);
    tick(); tick();
    check("pre_rst_pkt", pkt_data, 24'h0A5FFB);
    #3;
    RESET_N = 1'b0;
    #1;
    check("async_pkt_valid", pkt_valid, 0);
    check("async_busy", busy, 0);
    check("async_lv", local_valid, 0);
    tick();
    RESET_N = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);
    spike(10'h001);
    check("post_rst_pend", busy, 1);
    tick(); tick();
    check("post_rst_empty", busy, 0);
    check("post_rst_nopkt", pkt_valid, 0);
    check("post_rst_nolv", local_valid, 0);
    cfg_write(CFG_PTR, 6'd7, 12'h001);
    cfg_write(CFG_DOWN, 6'd0, 12'h004);
    spike(10'h040);
    tick(); tick();
    check("rst_naddr_lv", local_valid, 10'h010);
    check("rst_naddr6", slot(4), 12'h006);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
